// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state encoding and width helpers for the ADC scan sequencer
package adc_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONVERT, S_STORE} state_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int acc_w(input int avg_log2);
    return 8 + avg_log2;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: lowest enabled channel strictly above last, else wrap to the lowest enabled channel
module rr_pick
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   next,
  output logic              wrap
);
  logic [CH_W-1:0] lo, hi;
  logic hi_found;
  always_comb begin
    lo = '0;
    hi = '0;
    hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) lo = CH_W'(i);
      if (mask[i] && i > int'(last)) begin
        hi = CH_W'(i);
        hi_found = 1'b1;
      end
    end
    wrap = !hi_found;
    next = hi_found ? hi : lo;
  end
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin SAR ADC channel scanner with burst averaging and a result bank
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SETTLE_CYCLES = 1000,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT_CYCLES = 200000,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              err_clr,
  output logic              sar_go,
  input  logic              sar_valid,
  input  logic [7:0]        sar_result,
  output logic [CH_W-1:0]   mux_sel,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_chan,
  output logic [7:0]        res_data,
  output logic              scan_done,
  input  logic [CH_W-1:0]   rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              timeout_err
);
  localparam int ACC_W = acc_w(AVG_LOG2);
  localparam int N_W = AVG_LOG2 + 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [N_W-1:0] N_LAST = N_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_END = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic [CH_W-1:0] mux_q, mux_d, last_q, last_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0] n_q, n_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0] bank_q [NUM_CH];
  logic [7:0] bank_d [NUM_CH];
  logic [7:0] rd_q, rd_d, avg;
  logic err_q, err_d, timeout, store, wrap;

  rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .mask(chan_mask),
    .last(last_q),
    .next(pick),
    .wrap(wrap)
  );

  assign store = state_q == S_STORE;
  assign avg = acc_q[ACC_W-1:AVG_LOG2];
  assign sar_go = state_q == S_CONVERT;
  assign busy = state_q != S_IDLE;
  assign res_valid = store;
  assign res_chan = store ? last_q : '0;
  assign res_data = store ? avg : '0;
  assign scan_done = store && wrap;
  assign mux_sel = mux_q;
  assign rd_data = rd_q;
  assign timeout_err = err_q;

  always_comb begin
    state_d = state_q;
    mux_d = mux_q;
    last_d = last_q;
    cnt_d = cnt_q;
    n_d = n_q;
    acc_d = acc_q;
    timeout = 1'b0;
    bank_d = bank_q;
    if (store) bank_d[last_q] = avg;
    rd_d = (store && rd_addr == last_q) ? avg : (int'(rd_addr) < NUM_CH ? bank_q[rd_addr] : '0);
    case (state_q)
      S_IDLE: if (enable && |chan_mask) begin
        state_d = S_SETTLE;
        mux_d = pick;
        last_d = pick;
        cnt_d = '0;
      end
      S_SETTLE: if (cnt_q == SETTLE_END) begin
        state_d = S_CONVERT;
        cnt_d = '0;
        n_d = '0;
        acc_d = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_CONVERT: if (sar_valid) begin
        acc_d = acc_q + ACC_W'(sar_result);
        n_d = n_q + N_W'(1);
        cnt_d = '0;
        state_d = (n_q == N_LAST) ? S_STORE : S_CONVERT;
      end else if (cnt_q == WDOG_END) begin
        timeout = 1'b1;
        state_d = S_IDLE;
      end else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = S_IDLE;
    endcase
    // a timeout in the same cycle as err_clr keeps the error set
    err_d = (err_q && !err_clr) || timeout;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      mux_q <= '0;
      last_q <= CH_W'(NUM_CH - 1);
      cnt_q <= '0;
      n_q <= '0;
      acc_q <= '0;
      bank_q <= '{default: '0};
      rd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mux_q <= mux_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      acc_q <= acc_d;
      bank_q <= bank_d;
      rd_q <= rd_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: SAR core model plus transaction-level scoreboard, directed tables and random scans
module tb_adc_scan_sequencer;
  localparam int NCH = 4, SET = 10, ALOG = 2, TMO = 100, LAT = 20, NAVG = 1 << ALOG;

  logic clk = 0, reset = 1, enable = 0, err_clr = 0, sar_valid = 0;
  logic [3:0] chan_mask = 0;
  logic [7:0] sar_result = 0;
  logic [1:0] rd_addr = 0;
  logic sar_go, res_valid, scan_done, busy, timeout_err;
  logic [1:0] mux_sel, res_chan;
  logic [7:0] res_data, rd_data;

  int checks = 0, failures = 0;
  bit rand_mode = 0, withhold = 0, stray = 0;
  int rd_force = -1;

  logic [7:0] mbank [NCH];
  logic [7:0] burst [$];
  logic [7:0] exp_rd = 0;
  logic [3:0] p_mask = 0;
  int m_last = NCH - 1, cnt = 0, idle_run = 0, settle_n = 0, sum = 0;
  bit exp_err = 0, p_busy = 1, p_go = 0, p_en = 0, p_clr = 0, tmo = 0;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.NUM_CH(NCH), .SETTLE_CYCLES(SET), .AVG_LOG2(ALOG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask), .err_clr(err_clr),
    .sar_go(sar_go), .sar_valid(sar_valid), .sar_result(sar_result), .mux_sel(mux_sel),
    .res_valid(res_valid), .res_chan(res_chan), .res_data(res_data), .scan_done(scan_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int rr(input logic [3:0] m, input int last);
    for (int i = last + 1; i < NCH; i++) if (m[i]) return i;
    for (int i = 0; i < NCH; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic bit none_above(input logic [3:0] m, input int last);
    for (int i = last + 1; i < NCH; i++) if (m[i]) return 0;
    return 1;
  endfunction

  // scoreboard and SAR core model share one process so their ordering per cycle is fixed
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        foreach (mbank[i]) mbank[i] = 0;
        burst.delete();
        m_last = NCH - 1;
        cnt = 0;
        idle_run = 0;
        settle_n = 0;
        exp_err = 0;
        p_busy = 1;
        p_go = 0;
        sar_valid = 0;
        chk("reset_outputs", {sar_go, busy, res_valid, scan_done, timeout_err, mux_sel, res_chan, res_data, rd_data}, 0);
        exp_rd = 0;
      end else begin
        chk("rd_data", rd_data, exp_rd);
        tmo = p_go && !sar_go && !res_valid;
        if (tmo) chk("timeout_len", idle_run, TMO);
        exp_err = (exp_err && !p_clr) || tmo;
        chk("timeout_err", timeout_err, exp_err);
        if (!p_busy) begin
          chk("idle_exit", busy, p_en && (p_mask != 0));
          if (busy && p_mask != 0) begin
            m_last = rr(p_mask, m_last);
            chk("pick", mux_sel, m_last);
            settle_n = 0;
          end
        end
        if (busy && !sar_go && !res_valid) settle_n++;
        if (sar_go && !p_go) chk("settle_len", settle_n, SET);
        if (res_valid) begin
          sum = 0;
          foreach (burst[i]) sum += burst[i];
          chk("res_count", burst.size(), NAVG);
          chk("res_data", res_data, sum >> ALOG);
          chk("res_chan", res_chan, m_last);
          chk("scan_done", scan_done, none_above(chan_mask, m_last));
          mbank[m_last] = 8'(sum >> ALOG);
        end else if (scan_done) chk("stray_done", scan_done, 0);
        if (!sar_go) burst.delete();
      end
      rd_addr = (rd_force >= 0) ? 2'(rd_force) : 2'($urandom_range(0, NCH - 1));
      exp_rd = reset ? 8'd0 : mbank[rd_addr];
      sar_valid = 0;
      if (!reset && !sar_go) begin
        cnt = 0;
        if (stray && $urandom_range(0, 7) == 0) begin
          sar_valid = 1;
          sar_result = 8'($urandom);
        end
      end else if (!reset) begin
        cnt++;
        idle_run = p_go ? idle_run + 1 : 1;
        if (cnt >= LAT && !withhold) begin
          cnt = 0;
          idle_run = 0;
          sar_result = rand_mode ? 8'($urandom) : 8'(mux_sel * 40 + burst.size());
          sar_valid = 1;
          burst.push_back(sar_result);
        end
      end
      if (!reset) begin
        p_busy = busy;
        p_go = sar_go;
      end
      p_en = enable;
      p_mask = chan_mask;
      p_clr = err_clr;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    enable = 0;
    reset = 1;
    step(2);
    reset = 0;
  endtask

  task automatic wait_res(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      ok = res_valid;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_res expired after %0d cycles", budget);
    end
  endtask

  task automatic wait_for(input int kind, input int ch, input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      step(1);
      hit = (kind == 0) ? (sar_go && mux_sel == 2'(ch)) : (kind == 1) ? busy : timeout_err;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL %s wait expired after %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [2:0][1:0] ch;
    logic [2:0][7:0] data;
    logic [2:0] done;
  } vec_t;
  vec_t tbl [5];

  initial begin
    bit ok;
    int seen;
    // entries list the three stored results last-first; SAR model returns chan*40+k
    tbl[0] = '{4'b0101, {2'd0, 2'd2, 2'd0}, {8'd1, 8'd81, 8'd1}, 3'b010};
    tbl[1] = '{4'b1000, {2'd3, 2'd3, 2'd3}, {8'd121, 8'd121, 8'd121}, 3'b111};
    tbl[2] = '{4'b0110, {2'd1, 2'd2, 2'd1}, {8'd41, 8'd81, 8'd41}, 3'b010};
    tbl[3] = '{4'b1111, {2'd2, 2'd1, 2'd0}, {8'd81, 8'd41, 8'd1}, 3'b000};
    tbl[4] = '{4'b1001, {2'd0, 2'd3, 2'd0}, {8'd1, 8'd121, 8'd1}, 3'b010};
    step(1);
    foreach (tbl[r]) begin
      do_reset();
      chan_mask = tbl[r].mask;
      enable = 1;
      for (int k = 0; k < 3; k++) begin
        wait_res(300, ok);
        if (ok) begin
          chk($sformatf("tbl%0d_ch%0d", r, k), res_chan, tbl[r].ch[k]);
          chk($sformatf("tbl%0d_data%0d", r, k), res_data, tbl[r].data[k]);
          chk($sformatf("tbl%0d_done%0d", r, k), scan_done, tbl[r].done[k]);
        end
      end
      if (r == 1) begin
        rd_force = 3;
        step(2);
        chk("bank_ch3", rd_data, 121);
        rd_force = -1;
      end
    end

    do_reset();
    chan_mask = 4'b1111;
    enable = 1;
    wait_for(0, 1, 400, "go_ch1");
    step(30);
    enable = 0;
    wait_res(300, ok);
    if (ok) begin
      chk("drain_ch", res_chan, 1);
      chk("drain_data", res_data, 41);
    end
    step(5);
    chk("halt_busy", busy, 0);
    chk("halt_go", sar_go, 0);
    enable = 1;
    wait_for(1, 0, 20, "resume");
    chk("resume_ch", mux_sel, 2);

    do_reset();
    chan_mask = 4'b1111;
    withhold = 1;
    enable = 1;
    seen = 0;
    for (int i = 0; i < 300 && !timeout_err; i++) begin
      step(1);
      seen += int'(res_valid);
    end
    chk("tmo_set", timeout_err, 1);
    chk("tmo_no_result", seen, 0);
    chk("tmo_ch", mux_sel, 0);
    withhold = 0;
    wait_res(300, ok);
    if (ok) chk("tmo_next_ch", res_chan, 1);
    rd_force = 0;
    step(2);
    chk("tmo_no_store", rd_data, 0);
    rd_force = -1;
    chk("tmo_sticky", timeout_err, 1);
    err_clr = 1;
    step(1);
    err_clr = 0;
    chk("tmo_clear", timeout_err, 0);

    do_reset();
    chan_mask = 4'b1111;
    enable = 1;
    rd_force = 0;
    wait_res(300, ok);
    step(2);
    chk("pre_reset_rd", rd_data, 1);
    wait_for(0, 1, 100, "go_ch1_rst");
    step(5);
    reset = 1;
    #1;
    chk("async_go", sar_go, 0);
    chk("async_busy", busy, 0);
    chk("async_rd", rd_data, 0);
    chk("async_res", {res_valid, res_chan, res_data}, 0);
    step(2);
    reset = 0;
    rd_force = -1;
    wait_for(1, 0, 20, "restart");
    chk("restart_ch", mux_sel, 0);

    do_reset();
    chan_mask = 0;
    enable = 1;
    step(20);
    chk("nomask_busy", busy, 0);
    chk("nomask_go", sar_go, 0);
    chan_mask = 4'b0010;
    step(1);
    chk("mask_busy", busy, 1);
    chk("mask_ch", mux_sel, 1);

    do_reset();
    rand_mode = 1;
    stray = 1;
    for (int i = 0; i < 60; i++) begin
      chan_mask = 4'($urandom);
      enable = $urandom_range(0, 5) != 0;
      err_clr = $urandom_range(0, 3) == 0;
      withhold = $urandom_range(0, 9) == 0;
      step(1);
      err_clr = 0;
      step($urandom_range(20, 120));
    end
    withhold = 0;
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL global_timeout simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
